zigzag_scan_8in8: RTL
=====================

# zigzag_scan_8in8

Serializes quantized 8x8 blocks into zigzag order, one coefficient per clock. Sits directly downstream of the quantization stage. Each MCU is captured as three parallel 640-bit blocks (Y, Cb, Cr). The block emits 192 coefficients per MCU under a valid/ready handshake toward the entropy coder. A two-entry ping-pong buffer allows back-to-back MCUs with no output gap.

## Interface
Parameters:
- COEF_W, 10, signed coefficient width. Block bus width is 64*COEF_W.

Ports:
- clk  in  1  clock. Rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  one-cycle pulse: Y_in/Cb_in/Cr_in hold a valid MCU. This is the quantization stage's data_valid.
- Y_in, Cb_in, Cr_in  in  640 each  raster-order blocks. Coefficient k = 8*row+col sits at bits [10k+9:10k], two's complement.
- in_ready  out  1  at least one buffer entry free.
- coef_out  out  10  current coefficient.
- comp_id  out  2  component of the beat: 0=Y, 1=Cb, 2=Cr.
- zz_idx  out  6  zigzag position, 0..63.
- last_blk  out  1  beat is zz_idx 63.
- last_mcu  out  1  beat is zz_idx 63 of Cr.
- data_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat.
- overflow  out  1  sticky: an MCU was dropped.

## Operation
- Buffer: two entries of 1920 bits each, with write pointer wp, read pointer rp, and count cnt (0..2).
- in_ready = (cnt != 2), combinational from registered cnt.
- Accept: when enable && in_ready, all three inputs are written to entry wp, wp toggles, and cnt increments.
- Drop: when enable && !in_ready, inputs are discarded and overflow is set to 1. overflow clears only on reset.
- Scan FSM, IDLE:
  - data_valid=0.
  - If cnt>0, go to SCAN with comp=0, pos=0.
- Scan FSM, SCAN: data_valid=1 and the outputs present entry rp, component comp, raster index ZZ[pos].
- Advance on the handshake (data_valid && out_ready):
  - pos increments.
  - At pos 63, pos wraps to 0 and comp increments.
  - At comp=2, pos=63 the entry is released: rp toggles and cnt decrements. The FSM goes back to pos 0, comp 0 if another entry is full (cnt after release > 0); otherwise it goes to IDLE.
- If an accept and a release happen in the same cycle, cnt stays unchanged.
- ZZ table, position 0..63 to raster index: 0,1,8,16,9,2,3,10,17,24,32,25,18,11,4,5,12,19,26,33,40,48,41,34,27,20,13,6,7,14,21,28,35,42,49,56,57,50,43,36,29,22,15,23,30,37,44,51,58,59,52,45,38,31,39,46,53,60,61,54,47,55,62,63.
- Coefficients pass through bit-exact. There is no arithmetic and no sign alteration.
- While data_valid && !out_ready, coef_out, comp_id, zz_idx, last_blk and last_mcu hold stable.
- Once data_valid is asserted, it does not drop until the handshake completes.

## Timing
- All outputs are registered.
- Reset values: data_valid=0, coef_out=0, comp_id=0, zz_idx=0, last_blk=0, last_mcu=0, overflow=0, in_ready=1. Internally wp=rp=cnt=0 and the FSM is in IDLE. Buffer contents are not reset.
- Latency: with enable accepted at edge t into an empty block, the first beat (Y, zz 0) is valid after edge t+1.
- Throughput: with out_ready held at 1, one beat per clock.
  - One MCU takes 192 cycles.
  - A second MCU already buffered starts on the cycle right after last_mcu, with no bubble.
- Reset asserted mid-scan:
  - Outputs go to their reset values immediately (asynchronously).
  - Buffered MCUs are discarded.
  - After reset is released, nothing is emitted until a new enable.

## Test plan
- Single MCU, out_ready=1. Inputs: Y coef k = k, Cb coef k = 100+k, Cr coef k = -k. Required:
  - 192 consecutive beats.
  - Y sequence 0,1,8,16,9,2,... ending 62,63.
  - Cb sequence 100,101,108,....
  - Cr sequence 0,-1,-8,... (10'h3FF for -1).
  - last_blk on beats 63, 127 and 191; last_mcu only on beat 191.
- Backpressure: toggle out_ready pseudo-randomly. Required:
  - The emitted sequence is identical to the previous test.
  - Outputs stay stable during every stall.
  - Exactly 192 handshakes.
- Back-to-back: two enables 1 cycle apart. Required:
  - 384 beats with no data_valid gap.
  - in_ready=0 from the cycle after the second accept until the release of the first MCU.
- Overflow: out_ready=0, three enables. Required:
  - The first two are accepted; the third is dropped and overflow=1.
  - After out_ready=1, exactly 384 beats from MCUs 1 and 2.
- Extremes: Y coef 0 = 10'h200 (-512) and Y coef 63 = 10'h1FF (+511). Required: beat 0 = 10'h200 and beat 63 = 10'h1FF, bit-exact.
- Reset mid-scan: assert reset low at beat 50 of MCU 1 while MCU 2 is buffered. Required:
  - data_valid=0 immediately and all outputs at their reset values.
  - After release, no beats are emitted.
  - A new enable restarts cleanly at Y zz 0.

Source files
------------

// File: rtl/zigzag_scan_8in8.sv
// Two-entry ping-pong MCU buffer feeding a zigzag serializer: one coefficient per beat, Y then Cb then Cr.
// First beat registered one cycle after accept; outputs hold while out_ready is low, in_ready drops when both entries are full.
module zigzag_scan_8in8 #(
    parameter int COEF_W = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [64*COEF_W-1:0]  Y_in,
    input  logic [64*COEF_W-1:0]  Cb_in,
    input  logic [64*COEF_W-1:0]  Cr_in,
    output logic                  in_ready,
    output logic [COEF_W-1:0]     coef_out,
    output logic [1:0]            comp_id,
    output logic [5:0]            zz_idx,
    output logic                  last_blk,
    output logic                  last_mcu,
    output logic                  data_valid,
    input  logic                  out_ready,
    output logic                  overflow
);

    localparam int BLK_W = 64 * COEF_W;
    localparam int MCU_W = 3 * BLK_W;

    localparam logic [5:0] ZZ [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SCAN = 1'b1
    } state_t;

    logic [MCU_W-1:0]  r_buf [2];
    logic              r_wp;
    logic              r_rp;
    logic [1:0]        r_cnt;
    state_t            r_state;
    logic [5:0]        r_pos;
    logic [1:0]        r_comp;
    logic [COEF_W-1:0] r_coef;
    logic              r_last_blk;
    logic              r_last_mcu;
    logic              r_dv;
    logic              r_ovf;

    logic              w_in_rdy;
    logic              w_acc;
    logic              w_drop;
    logic              w_hs;
    logic              w_rel;
    logic [1:0]        w_cnt_nxt;
    logic              w_ld;
    logic              w_ld_ent;
    logic [1:0]        w_ld_comp;
    logic [5:0]        w_ld_pos;
    logic [MCU_W-1:0]  w_blk;
    logic [7:0]        w_sel;
    logic [COEF_W-1:0] w_coef;

    assign w_in_rdy = (r_cnt != 2'd2);
    assign w_acc    = enable & w_in_rdy;
    assign w_drop   = enable & ~w_in_rdy;
    assign w_hs     = r_dv & out_ready;
    assign w_rel    = w_hs & (r_comp == 2'd2) & (r_pos == 6'd63);

    always_comb begin
        w_cnt_nxt = r_cnt;
        case ({w_acc, w_rel})
            2'b10:   w_cnt_nxt = r_cnt + 2'd1;
            2'b01:   w_cnt_nxt = r_cnt - 2'd1;
            default: w_cnt_nxt = r_cnt;
        endcase
    end

    // Selects which beat gets loaded into the output registers at the next edge.
    always_comb begin
        w_ld      = 1'b0;
        w_ld_ent  = r_rp;
        w_ld_comp = 2'd0;
        w_ld_pos  = 6'd0;
        case (r_state)
            S_IDLE: begin
                w_ld = (r_cnt != 2'd0);
            end
            S_SCAN: begin
                if (w_rel) begin
                    w_ld     = (w_cnt_nxt != 2'd0);
                    w_ld_ent = ~r_rp;
                end else if (w_hs) begin
                    w_ld = 1'b1;
                    if (r_pos == 6'd63) begin
                        w_ld_comp = r_comp + 2'd1;
                        w_ld_pos  = 6'd0;
                    end else begin
                        w_ld_comp = r_comp;
                        w_ld_pos  = r_pos + 6'd1;
                    end
                end
            end
            default: w_ld = 1'b0;
        endcase
    end

    // An MCU written on the same edge that the previous one is released must bypass the buffer.
    assign w_blk  = (w_acc && (r_wp == w_ld_ent)) ? {Cr_in, Cb_in, Y_in} : r_buf[w_ld_ent];
    assign w_sel  = {w_ld_comp, ZZ[w_ld_pos]};
    assign w_coef = w_blk[w_sel*COEF_W +: COEF_W];

    always_ff @(posedge clk) begin
        if (w_acc) begin
            r_buf[r_wp] <= {Cr_in, Cb_in, Y_in};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wp       <= 1'b0;
            r_rp       <= 1'b0;
            r_cnt      <= 2'd0;
            r_state    <= S_IDLE;
            r_pos      <= 6'd0;
            r_comp     <= 2'd0;
            r_coef     <= '0;
            r_last_blk <= 1'b0;
            r_last_mcu <= 1'b0;
            r_dv       <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            if (w_acc) begin
                r_wp <= ~r_wp;
            end
            if (w_rel) begin
                r_rp <= ~r_rp;
            end
            r_cnt <= w_cnt_nxt;
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
            if (w_ld) begin
                r_state    <= S_SCAN;
                r_dv       <= 1'b1;
                r_pos      <= w_ld_pos;
                r_comp     <= w_ld_comp;
                r_coef     <= w_coef;
                r_last_blk <= (w_ld_pos == 6'd63);
                r_last_mcu <= (w_ld_pos == 6'd63) && (w_ld_comp == 2'd2);
            end else if (r_state == S_SCAN && w_hs) begin
                r_state    <= S_IDLE;
                r_dv       <= 1'b0;
                r_last_blk <= 1'b0;
                r_last_mcu <= 1'b0;
            end
        end
    end

    assign in_ready   = w_in_rdy;
    assign coef_out   = r_coef;
    assign comp_id    = r_comp;
    assign zz_idx     = r_pos;
    assign last_blk   = r_last_blk;
    assign last_mcu   = r_last_mcu;
    assign data_valid = r_dv;
    assign overflow   = r_ovf;

endmodule
